// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default sizes for the unified memory arbiter.
// Optional feature macro used by the arbiter: ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEM_LAT = 2;

    // Width needed to hold the values 0..lat
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the arbiter.
// master: CPU stages plus memory model; slave: the arbiter itself.
interface unified_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_f;
    logic              stall_m;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_valid, d_rdata, d_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_valid, d_rdata, d_valid,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

endinterface

// File: rtl/unified_mem_arbiter_wait_counter.sv
// Loadable down-counter timing the memory access; zero marks the last BUSY cycle.
module wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CW = cnt_width(MEM_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

    logic [CW-1:0] cnt_reg;

    // Load remaining wait cycles on grant, count down while the access runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= LOAD_VAL;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch (I) and memory (D) stages.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner of simultaneous requests;
// otherwise the data side always wins a tie.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    unified_mem_arbiter_if.slave   bus
);
    state_e            state_reg;
    state_e            state_next;
    side_e             side_reg;
    side_e             grant_side;
    logic              grant;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              cnt_zero;
    logic              capture;
    logic              d_priority;

`ifdef ARB_ROUND_ROBIN_EN
    side_e last_grant_reg;

    // Remember who won most recently; starts as D so the first tie goes to I
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= SIDE_D;
        end else if (grant) begin
            last_grant_reg <= grant_side;
        end
    end

    assign d_priority = (last_grant_reg == SIDE_I);
`else
    assign d_priority = 1'b1;
`endif

    // D wins a tie when it has priority; a lone requester always wins
    assign grant_side = (bus.d_req && (!bus.i_req || d_priority)) ? SIDE_D : SIDE_I;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and grant decision; requests are only looked at in IDLE
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    grant      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the granted access so requester changes mid-access are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            side_reg  <= SIDE_D;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (grant) begin
            side_reg <= grant_side;
            if (grant_side == SIDE_D) begin
                we_reg    <= bus.d_we;
                addr_reg  <= bus.d_addr;
                wdata_reg <= bus.d_wdata;
            end else begin
                we_reg    <= 1'b0;
                addr_reg  <= bus.i_addr;
            end
        end
    end

    wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (grant),
        .en    (state_reg == BUSY),
        .zero  (cnt_zero)
    );

    // Read data is taken on the last BUSY cycle; writes leave rdata untouched
    assign capture = (state_reg == BUSY) && cnt_zero && !we_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            localparam side_e OWN_SIDE = (gi == 0) ? SIDE_I : SIDE_D;
            logic [DATA_W-1:0] rdata_reg;

            // Per-side read data register, updated only by that side's reads
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (capture && (side_reg == OWN_SIDE)) begin
                    rdata_reg <= bus.mem_rdata;
                end
            end
        end
    endgenerate

    assign bus.i_rdata   = g_rdata[0].rdata_reg;
    assign bus.d_rdata   = g_rdata[1].rdata_reg;

    assign bus.mem_en    = (state_reg == BUSY);
    assign bus.mem_we    = (state_reg == BUSY) && we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;

    assign bus.i_valid   = (state_reg == DONE) && (side_reg == SIDE_I);
    assign bus.d_valid   = (state_reg == DONE) && (side_reg == SIDE_D);

    assign bus.stall_f   = bus.i_req & ~bus.i_valid;
    assign bus.stall_m   = bus.d_req & ~bus.d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a completion scoreboard.
// Honours ARB_ROUND_ROBIN_EN when choosing tie expectations.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    endtask

    // Memory model: writes land and read data is presented at each negedge
    logic [31:0] store [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (store.exists(a)) return store[a];
        return {a[15:0], ~a[31:16]};
    endfunction

    always @(negedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) store[bus.mem_addr] = bus.mem_wdata;
        bus.mem_rdata  = mem_read(bus.mem_addr);
        bus1.mem_rdata = mem_read(bus1.mem_addr);
    end

    // Scoreboard of expected completions on the main instance
    typedef struct {
        side_e       side;
        logic [31:0] data;
        string       tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] i_exp = '0;
    logic [31:0] d_exp = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.i_valid === 1'b1 || bus.d_valid === 1'b1)) begin
            if (sb.size() == 0) begin
                check("sb_extra_valid", {62'd0, bus.i_valid, bus.d_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_valid"}, {62'd0, bus.i_valid, bus.d_valid},
                      (mon_e.side == SIDE_D) ? 64'd1 : 64'd2);
                check({mon_e.tag, "_rdata"},
                      (mon_e.side == SIDE_D) ? bus.d_rdata : bus.i_rdata, mon_e.data);
                $display("txn %s side=%s i_rdata=0x%08h d_rdata=0x%08h", mon_e.tag,
                         (mon_e.side == SIDE_D) ? "D" : "I", bus.i_rdata, bus.d_rdata);
            end
        end
    end

    task automatic push(input string tag, input side_e side, input logic [31:0] data);
        exp_t e;
        e.side = side;
        e.data = data;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One access from an idle start; waits (bounded) for its completion
    task automatic single_access(input string tag, input bit is_d, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data);
        int n;
        push(tag, is_d ? SIDE_D : SIDE_I, exp_data);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_done"}, sb.size(), 64'd0);
        sb.delete();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    // Simultaneous I and D reads; cycle-exact expectations for valids and stalls
    task automatic run_tie(input string tag, input bit d_first,
                           input logic [31:0] ia, input logic [31:0] ie,
                           input logic [31:0] da, input logic [31:0] de);
        int first_v;
        int second_v;
        first_v  = LAT + 1;
        second_v = 2 * (LAT + 2) - 1;
        if (d_first) begin
            push({tag, "_d"}, SIDE_D, de);
            push({tag, "_i"}, SIDE_I, ie);
        end else begin
            push({tag, "_i"}, SIDE_I, ie);
            push({tag, "_d"}, SIDE_D, de);
        end
        bus.i_req = 1'b1; bus.i_addr = ia;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
        for (int k = 0; k <= second_v; k++) begin
            @(negedge clk);
            if (d_first) begin
                check($sformatf("%s_stall_f_c%0d", tag, k), bus.stall_f, (k != second_v));
                check($sformatf("%s_stall_m_c%0d", tag, k), bus.stall_m, (k < first_v));
            end else begin
                check($sformatf("%s_stall_f_c%0d", tag, k), bus.stall_f, (k < first_v));
                check($sformatf("%s_stall_m_c%0d", tag, k), bus.stall_m, (k != second_v));
            end
            cyc();
            if (k == first_v) begin
                if (d_first) bus.d_req = 1'b0; else bus.i_req = 1'b0;
            end
            if (k == second_v) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        check({tag, "_sb_empty"}, sb.size(), 64'd0);
        sb.delete();
        i_exp = ie;
        d_exp = de;
    endtask

    initial begin
        store[32'h0000_0040] = 32'h2008_000A;
        rst_n = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0;
        bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;

        // Reset state
        #2;
        check("rst_ctrl", {bus.mem_en, bus.mem_we, bus.i_valid, bus.d_valid}, 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
        check("rst_stalls", {bus.stall_f, bus.stall_m}, 64'd2);
        bus.i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // I read: BUSY on cycles 1-2, i_valid on cycle 3
        push("t1_iread", SIDE_I, 32'h2008_000A);
        i_exp = 32'h2008_000A;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t1_mem_en_c%0d", k), bus.mem_en, (k == 1 || k == 2));
            check($sformatf("t1_stall_f_c%0d", k), bus.stall_f, (k <= 2));
            check($sformatf("t1_i_valid_c%0d", k), bus.i_valid, (k == 3));
            if (k == 1) check("t1_mem_addr", {bus.mem_we, bus.mem_addr}, 64'h0000_0040);
            cyc();
        end
        bus.i_req = 1'b0;
        check("t1_sb_empty", sb.size(), 64'd0);
        cyc();

        // D write: strobe with held addr/data for LAT cycles, d_rdata unchanged
        push("t2_dwrite", SIDE_D, d_exp);
        bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_addr = 32'h7FF0_0010; bus.d_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t2_mem_we_c%0d", k), {bus.mem_en, bus.mem_we},
                  (k == 1 || k == 2) ? 64'd3 : 64'd0);
            if (k == 1 || k == 2) begin
                check($sformatf("t2_mem_addr_c%0d", k), bus.mem_addr, 64'h7FF0_0010);
                check($sformatf("t2_mem_wdata_c%0d", k), bus.mem_wdata, 64'hDEAD_BEEF);
            end
            check($sformatf("t2_d_valid_c%0d", k), bus.d_valid, (k == 3));
            cyc();
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        check("t2_sb_empty", sb.size(), 64'd0);
        cyc();

        // Tie, then a lone I read, then a tie that reads back the stored word
        run_tie("t3_tie1", !RR, 32'h0000_0100, mem_read(32'h0000_0100),
                32'h0000_0080, mem_read(32'h0000_0080));
        single_access("t3_lone_i", 1'b0, 1'b0, 32'h0000_0044, '0, mem_read(32'h0000_0044));
        i_exp = mem_read(32'h0000_0044);
        run_tie("t3_tie2", 1'b1, 32'h0000_0108, mem_read(32'h0000_0108),
                32'h7FF0_0010, 32'hDEAD_BEEF);

        // D read with request dropped and address changed right after grant
        push("t4_drop", SIDE_D, mem_read(32'h0000_0200));
        d_exp = mem_read(32'h0000_0200);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2) begin
                check($sformatf("t4_mem_addr_c%0d", k), {bus.mem_en, bus.mem_addr},
                      {31'd0, 1'b1, 32'h0000_0200});
            end
            check($sformatf("t4_d_valid_c%0d", k), bus.d_valid, (k == 3));
            cyc();
            if (k == 0) begin
                bus.d_req = 1'b0; bus.d_addr = 32'h0000_0999;
            end
        end
        check("t4_sb_empty", sb.size(), 64'd0);

        // Reset during the second BUSY cycle aborts the access
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0300;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check("t5_mem_en_async", bus.mem_en, 64'd0);
        check("t5_rdata_cleared", {bus.i_rdata, bus.d_rdata}, 64'd0);
        i_exp = '0; d_exp = '0;
        bus.i_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t5_no_valid_c%0d", k), {bus.i_valid, bus.d_valid, bus.mem_en}, 64'd0);
            cyc();
        end
        single_access("t5_after", 1'b0, 1'b0, 32'h0000_0040, '0, 32'h2008_000A);
        cyc();

        // MEM_LAT=1 instance: back-to-back I reads every 3 cycles
        bus1.i_req = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            bus1.i_addr = 32'h0000_1000 + 32'(4 * k);
            @(negedge clk);
            check($sformatf("t6_i_valid_c%0d", k), bus1.i_valid, (k % 3 == 2));
            check($sformatf("t6_stall_f_c%0d", k), bus1.stall_f, (k % 3 != 2));
            if (k % 3 == 1) begin
                check($sformatf("t6_mem_addr_c%0d", k), {bus1.mem_en, bus1.mem_addr},
                      {31'd0, 1'b1, 32'h0000_1000 + 32'(4 * (k - 1))});
            end
            if (k % 3 == 2) begin
                check($sformatf("t6_hold_addr_c%0d", k), bus1.mem_addr,
                      32'h0000_1000 + 32'(4 * (k - 2)));
                check($sformatf("t6_i_rdata_c%0d", k), bus1.i_rdata,
                      mem_read(32'h0000_1000 + 32'(4 * (k - 2))));
                $display("txn t6 lat1 cycle=%0d i_rdata=0x%08h", k, bus1.i_rdata);
            end
            cyc();
        end
        bus1.i_req = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
